// File: rtl/dma_pcie_crdt_pkg.sv
// Shared types and helpers for the PCIe DMA credit link.
// Channel types are sized for the widest supported link (16 channels).
package dma_pcie_crdt_pkg;

    localparam int MAX_CH_BITS = 4;
    localparam int MAX_CH      = 1 << MAX_CH_BITS;

    typedef logic [MAX_CH_BITS-1:0] ch_t;
    typedef logic [7:0]             cnt_t;

    function automatic int num_ch(input int ch_bits);
        return 1 << ch_bits;
    endfunction

    // First requester strictly after 'last', wrapping over n (power of 2) channels.
    // With no request pending, 'last' is returned unchanged.
    function automatic ch_t rr_pick(input logic [MAX_CH-1:0] req, input ch_t last, input int n);
        ch_t  pick;
        ch_t  idx;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = ch_t'((int'(last) + i) & (n - 1));
            if (i <= n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_pcie_crdt_fifo.sv
// Single-channel first-word-fall-through FIFO; the caller never pushes
// into a full FIFO without a simultaneous pop and never pops when empty.
module dma_pcie_crdt_fifo #(
    parameter int DATA_BITS = 512,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_BITS-1:0]         wdata,
    output logic [DATA_BITS-1:0]         rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_pcie_crdt_rx.sv
// Credit-issuing receiver: per-channel FIFOs, round-robin drain to the DMA core,
// and one registered credit return per cycle for every freed entry.
module dma_pcie_crdt_rx
    import dma_pcie_crdt_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int CH_BITS   = 2,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tl_tdata,
    input  logic                 tl_tvld,
    input  logic [CH_BITS-1:0]   tl_tch,
    output logic                 tl_crdt,
    output logic [CH_BITS-1:0]   tl_crdt_ch,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic [CH_BITS-1:0]   m_tch,
    output logic                 m_tvld,
    input  logic                 m_trdy,
    output logic                 err_ovf
);
    localparam int NUM_CH = num_ch(CH_BITS);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]    fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ne;
    logic [DATA_BITS-1:0] fifo_rdata [NUM_CH];
    logic [CNT_W-1:0]     fifo_count [NUM_CH];

    logic [CH_BITS-1:0] drain_ptr_q, drain_ptr_d, drain_last, drain_sel;
    logic [CH_BITS-1:0] lock_ch_q, lock_ch_d;
    logic               lock_vld_q, lock_vld_d;
    logic               drain_vld;
    logic               err_ovf_q, err_ovf_d;

    logic [NUM_CH-1:0]  crdt_req;
    logic               crdt_any;
    logic [CH_BITS-1:0] crdt_ptr_q, crdt_ptr_d, crdt_last, crdt_sel;
    logic               tl_crdt_q, tl_crdt_d;
    logic [CH_BITS-1:0] tl_crdt_ch_q, tl_crdt_ch_d;
    logic [CNT_W-1:0]   pending_q [NUM_CH];
    logic [CNT_W-1:0]   pending_d [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        dma_pcie_crdt_fifo #(
            .DATA_BITS (DATA_BITS),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .wdata (tl_tdata),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .count (fifo_count[g])
        );
    end

    // Drain: pointers hold the next channel to favour; a stalled grant is locked.
    always_comb begin
        fifo_ne     = ~fifo_empty;
        drain_last  = drain_ptr_q - CH_BITS'(1);
        drain_sel   = lock_vld_q ? lock_ch_q
                                 : CH_BITS'(rr_pick(MAX_CH'(fifo_ne), ch_t'(drain_last), NUM_CH));
        drain_vld   = (fifo_count[drain_sel] != '0);
        fifo_pop    = '0;
        if (drain_vld && m_trdy) begin
            fifo_pop[drain_sel] = 1'b1;
        end
        lock_vld_d  = drain_vld && !m_trdy;
        lock_ch_d   = lock_vld_d ? drain_sel : lock_ch_q;
        drain_ptr_d = (drain_vld && m_trdy) ? drain_sel + CH_BITS'(1) : drain_ptr_q;
    end

    // Ingress: a full FIFO still takes a beat when it is popped in the same cycle.
    always_comb begin
        fifo_push = '0;
        err_ovf_d = err_ovf_q;
        if (tl_tvld) begin
            if (!fifo_full[tl_tch] || fifo_pop[tl_tch]) begin
                fifo_push[tl_tch] = 1'b1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            crdt_req[c] = (pending_q[c] != '0);
        end
        crdt_any     = |crdt_req;
        crdt_last    = crdt_ptr_q - CH_BITS'(1);
        crdt_sel     = CH_BITS'(rr_pick(MAX_CH'(crdt_req), ch_t'(crdt_last), NUM_CH));
        tl_crdt_d    = crdt_any;
        tl_crdt_ch_d = crdt_any ? crdt_sel : tl_crdt_ch_q;
        crdt_ptr_d   = crdt_any ? crdt_sel + CH_BITS'(1) : crdt_ptr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            pending_d[c] = pending_q[c] + CNT_W'(fifo_pop[c])
                         - CNT_W'(crdt_any && (crdt_sel == CH_BITS'(c)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_ptr_q  <= '0;
            lock_vld_q   <= 1'b0;
            lock_ch_q    <= '0;
            err_ovf_q    <= 1'b0;
            crdt_ptr_q   <= '0;
            tl_crdt_q    <= 1'b0;
            tl_crdt_ch_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pending_q[c] <= CNT_W'(DEPTH);
            end
        end else begin
            drain_ptr_q  <= drain_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_ch_q    <= lock_ch_d;
            err_ovf_q    <= err_ovf_d;
            crdt_ptr_q   <= crdt_ptr_d;
            tl_crdt_q    <= tl_crdt_d;
            tl_crdt_ch_q <= tl_crdt_ch_d;
            for (int c = 0; c < NUM_CH; c++) begin
                pending_q[c] <= pending_d[c];
            end
        end
    end

    assign m_tvld     = drain_vld;
    assign m_tch      = drain_vld ? drain_sel : '0;
    assign m_tdata    = drain_vld ? fifo_rdata[drain_sel] : '0;
    assign err_ovf    = err_ovf_q;
    assign tl_crdt    = tl_crdt_q;
    assign tl_crdt_ch = tl_crdt_ch_q;

endmodule

// File: tb/tb_dma_pcie_crdt_rx.sv
// Bench for dma_pcie_crdt_rx: directed scenarios plus random traffic, checked
// against a queue-based model of channel FIFOs, drain order and credit timing.
module tb_dma_pcie_crdt_rx;

    localparam int DW    = 512;
    localparam int CHB   = 2;
    localparam int DEPTH = 4;
    localparam int NCH   = 1 << CHB;

    // Clock / reset and DUT
    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  tl_tdata;
    logic           tl_tvld;
    logic [CHB-1:0] tl_tch;
    logic           tl_crdt;
    logic [CHB-1:0] tl_crdt_ch;
    logic [DW-1:0]  m_tdata;
    logic [CHB-1:0] m_tch;
    logic           m_tvld;
    logic           m_trdy;
    logic           err_ovf;

    always #5 clk = ~clk;

    dma_pcie_crdt_rx #(
        .DATA_BITS (DW),
        .CH_BITS   (CHB),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tl_tdata   (tl_tdata),
        .tl_tvld    (tl_tvld),
        .tl_tch     (tl_tch),
        .tl_crdt    (tl_crdt),
        .tl_crdt_ch (tl_crdt_ch),
        .m_tdata    (m_tdata),
        .m_tch      (m_tch),
        .m_tvld     (m_tvld),
        .m_trdy     (m_trdy),
        .err_ovf    (err_ovf)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] exp_q [NCH][$];
    int  sender_cred [NCH];
    int  avail       [NCH];
    int  crd_cnt     [NCH];
    int  pop_log     [$];
    bit  mdl_ovf;
    int  mdl_ptr;
    bit  mdl_lock;
    int  mdl_lock_ch;
    bit  pd1_v, pd2_v;
    int  pd1_ch, pd2_ch;
    bit  mon_any;
    int  mon_ch;
    int  mon_c;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            sender_cred[c] = 0;
            avail[c]       = DEPTH;
        end
        mdl_ovf  = 1'b0;
        mdl_ptr  = 0;
        mdl_lock = 1'b0;
        pd1_v    = 1'b0;
        pd2_v    = 1'b0;
    endtask

    // Scoreboard: expectations come from the model state built up to the previous edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            mon_any = 1'b0;
            mon_ch  = 0;
            if (mdl_lock) begin
                mon_any = 1'b1;
                mon_ch  = mdl_lock_ch;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    mon_c = (mdl_ptr + k) % NCH;
                    if (!mon_any && exp_q[mon_c].size() > 0) begin
                        mon_any = 1'b1;
                        mon_ch  = mon_c;
                    end
                end
            end
            check_eq("m_tvld", m_tvld, mon_any);
            if (mon_any) begin
                check_eq("m_tch", m_tch, mon_ch);
                check_eq("m_tdata", m_tdata, exp_q[mon_ch][0]);
            end
            check_eq("err_ovf", err_ovf, mdl_ovf);

            // A freed entry may be credited no earlier than two cycles after its pop.
            if (pd2_v) avail[pd2_ch]++;
            if (tl_crdt) begin
                check_eq("crdt_legal", avail[tl_crdt_ch] > 0, 1'b1);
                if (avail[tl_crdt_ch] > 0) avail[tl_crdt_ch]--;
                sender_cred[tl_crdt_ch]++;
                crd_cnt[tl_crdt_ch]++;
            end
            pd2_v  = pd1_v;
            pd2_ch = pd1_ch;
            pd1_v  = 1'b0;

            if (mon_any && m_trdy) begin
                void'(exp_q[mon_ch].pop_front());
                pop_log.push_back(mon_ch);
                mdl_ptr  = (mon_ch + 1) % NCH;
                mdl_lock = 1'b0;
                pd1_v    = 1'b1;
                pd1_ch   = mon_ch;
            end else if (mon_any) begin
                mdl_lock    = 1'b1;
                mdl_lock_ch = mon_ch;
            end

            if (tl_tvld) begin
                if (sender_cred[tl_tch] > 0) sender_cred[tl_tch]--;
                if (exp_q[tl_tch].size() < DEPTH) exp_q[tl_tch].push_back(tl_tdata);
                else mdl_ovf = 1'b1;
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input logic [DW-1:0] d, input bit rdy);
        tl_tvld  = v;
        tl_tch   = CHB'(ch);
        tl_tdata = d;
        m_trdy   = rdy;
        cyc();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset(input int ncyc);
        rst     = 1'b1;
        tl_tvld = 1'b0;
        m_trdy  = 1'b0;
        repeat (ncyc) cyc();
        rst = 1'b0;
        check_eq("rst_crdt", tl_crdt, 1'b0);
        check_eq("rst_crdt_ch", tl_crdt_ch, '0);
        check_eq("rst_m_tvld", m_tvld, 1'b0);
        check_eq("rst_m_tch", m_tch, '0);
        check_eq("rst_m_tdata", m_tdata, '0);
        check_eq("rst_err_ovf", err_ovf, 1'b0);
        for (int i = 0; i < NCH * DEPTH; i++) begin
            cyc();
            check_eq("init_crdt_v", tl_crdt, 1'b1);
            check_eq("init_crdt_ch", tl_crdt_ch, i % NCH);
        end
        cyc();
        check_eq("init_done_crdt", tl_crdt, 1'b0);
        check_eq("init_done_tvld", m_tvld, 1'b0);
        check_eq("init_done_ovf", err_ovf, 1'b0);
    endtask

    // Drain everything and let every credit come home.
    task automatic settle();
        repeat (40) drive(1'b0, 0, '0, 1'b1);
        for (int c = 0; c < NCH; c++) check_eq("cred_restore", sender_cred[c], DEPTH);
    endtask

    logic [DW-1:0] hold_data;
    logic [CHB-1:0] hold_ch;
    bit  r_snd;
    int  r_ch, r_st, r_cc;

    initial begin
        rst      = 1'b1;
        tl_tvld  = 1'b0;
        tl_tch   = '0;
        tl_tdata = '0;
        m_trdy   = 1'b0;
        for (int c = 0; c < NCH; c++) crd_cnt[c] = 0;
        #1;
        do_reset(2);

        // Four beats on ch2, downstream always ready
        pop_log.delete();
        for (int c = 0; c < NCH; c++) crd_cnt[c] = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, 2, DW'('hA0 + i), 1'b1);
        settle();
        check_eq("ch2_pops", pop_log.size(), 4);
        for (int i = 0; i < pop_log.size(); i++) check_eq("ch2_pop_ch", pop_log[i], 2);
        check_eq("ch2_credits", crd_cnt[2], 4);

        // One beat per channel while stalled, then release
        pop_log.delete();
        for (int c = 0; c < NCH; c++) drive(1'b1, c, rand_data(), 1'b0);
        hold_data = m_tdata;
        hold_ch   = m_tch;
        check_eq("stall_valid", m_tvld, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, '0, 1'b0);
            check_eq("stall_data", m_tdata, hold_data);
            check_eq("stall_ch", m_tch, hold_ch);
        end
        settle();
        check_eq("rr_pops", pop_log.size(), 4);
        for (int i = 0; i < pop_log.size(); i++) check_eq("rr_order", pop_log[i], i);

        // Overflow on ch1: fifth beat without a credit is dropped
        pop_log.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 1, rand_data(), 1'b0);
        drive(1'b1, 1, rand_data(), 1'b0);
        check_eq("ovf_set", err_ovf, 1'b1);
        settle();
        check_eq("ovf_pops", pop_log.size(), 4);
        check_eq("ovf_sticky", err_ovf, 1'b1);

        do_reset(1);

        // Full ch3 with push and pop in the same cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 3, rand_data(), 1'b0);
        for (int c = 0; c < NCH; c++) crd_cnt[c] = 0;
        drive(1'b1, 3, rand_data(), 1'b1);
        repeat (6) drive(1'b0, 0, '0, 1'b0);
        check_eq("pp_credit_ch3", crd_cnt[3], 1);
        check_eq("pp_no_ovf", err_ovf, 1'b0);
        pop_log.delete();
        repeat (10) drive(1'b0, 0, '0, 1'b1);
        check_eq("pp_occupancy", pop_log.size(), 4);
        check_eq("pp_no_ovf_end", err_ovf, 1'b0);

        do_reset(1);

        // Reset with beats queued and credits pending
        for (int i = 0; i < 5; i++) drive(1'b1, i % NCH, rand_data(), 1'b0);
        repeat (2) drive(1'b0, 0, '0, 1'b1);
        do_reset(1);

        // Random traffic within the credit budget
        for (int n = 0; n < 800; n++) begin
            r_snd = 1'b0;
            r_ch  = 0;
            r_st  = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 99) < 60) begin
                for (int k = 0; k < NCH; k++) begin
                    r_cc = (r_st + k) % NCH;
                    if (!r_snd && sender_cred[r_cc] > 0) begin
                        r_snd = 1'b1;
                        r_ch  = r_cc;
                    end
                end
            end
            drive(r_snd, r_ch, rand_data(), $urandom_range(0, 99) < 70);
        end
        settle();
        check_eq("rand_no_ovf", err_ovf, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
